// File: rtl/mpc_types.sv
// Shared configuration and types for the mpc reference-count logic.
package mpc_types;

    typedef struct packed {
        int unsigned cnt_width;
        int unsigned way_num;
        int unsigned set_width;
        int unsigned inc_ports;
    } mpc_cfg_t;

    localparam mpc_cfg_t MPC_CFG = '{cnt_width: 3, way_num: 4, set_width: 6, inc_ports: 2};

    typedef logic [MPC_CFG.cnt_width-1:0] ref_cnt_t;

    localparam ref_cnt_t REF_CNT_MAX = '1;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ns_gnrl_dfflr.sv
// Generic load-enabled flop with async active-low reset to zero.
module ns_gnrl_dfflr #(
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/ref_cnt_cell.sv
// One saturating reference counter; clr has priority over any update.
module ref_cnt_cell #(
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned NI_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NI_W-1:0]      n_inc,
    input  logic                 d,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] cnt_nxt,
    output logic                 ovf_pulse,
    output logic                 udf_pulse
);

    localparam int unsigned SW = CNT_WIDTH + NI_W + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic signed [SW-1:0]  sum_c;
    logic                  active_c;
    logic                  lden_c;
    logic [CNT_WIDTH-1:0]  dnxt_c;

    assign sum_c     = $signed(SW'(cnt)) + $signed(SW'(n_inc)) - $signed(SW'(d));
    assign active_c  = (|n_inc) | d;
    assign ovf_pulse = !clr && active_c && (sum_c > $signed(SW'(CNT_MAX)));
    assign udf_pulse = !clr && active_c && sum_c[SW-1];
    assign lden_c    = clr | active_c;

    // Saturate high, clamp low, clear overrides both.
    always_comb begin
        dnxt_c = sum_c[CNT_WIDTH-1:0];
        if (ovf_pulse) begin
            dnxt_c = CNT_MAX;
        end else if (udf_pulse) begin
            dnxt_c = '0;
        end
        if (clr) begin
            dnxt_c = '0;
        end
    end

    assign cnt_nxt = lden_c ? dnxt_c : cnt;

    ns_gnrl_dfflr #(.DW(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (lden_c),
        .dnxt  (dnxt_c),
        .qout  (cnt)
    );

endmodule

// File: rtl/ref_cnt_array.sv
// Per-(way,set) saturating reference counters with lookup, sticky errors and clear sweep.
// Define REF_CNT_RD_BYPASS_EN to make lookups return the post-update counter values.
module ref_cnt_array
    import mpc_types::*;
#(
    parameter int unsigned CNT_WIDTH = MPC_CFG.cnt_width,
    parameter int unsigned WAY_NUM   = MPC_CFG.way_num,
    parameter int unsigned SET_WIDTH = MPC_CFG.set_width,
    parameter int unsigned INC_PORTS = MPC_CFG.inc_ports,
    parameter int unsigned WAY_IDX_W = idx_width(WAY_NUM)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_valid,
    input  logic [SET_WIDTH-1:0]           rd_set,
    output logic                           rsp_valid,
    output logic [WAY_NUM*CNT_WIDTH-1:0]   rsp_cnt,
    output logic [WAY_NUM-1:0]             rsp_ref_mask,
    input  logic [INC_PORTS-1:0]           inc_valid,
    input  logic [INC_PORTS*SET_WIDTH-1:0] inc_set,
    input  logic [INC_PORTS*WAY_IDX_W-1:0] inc_way,
    input  logic                           dec_valid,
    input  logic [WAY_IDX_W+SET_WIDTH-1:0] dec_way_set,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic                           err_ovf,
    output logic                           err_udf,
    input  logic                           err_clr
);

    localparam int unsigned SET_NUM = 1 << SET_WIDTH;
    localparam int unsigned NI_W    = $clog2(INC_PORTS + 1);
`ifdef REF_CNT_RD_BYPASS_EN
    localparam bit RD_BYPASS = 1'b1;
`else
    localparam bit RD_BYPASS = 1'b0;
`endif

    logic [CNT_WIDTH-1:0]         cnt_q   [SET_NUM][WAY_NUM];
    logic [CNT_WIDTH-1:0]         cnt_nxt [SET_NUM][WAY_NUM];
    logic [SET_NUM*WAY_NUM-1:0]   ovf_vec;
    logic [SET_NUM*WAY_NUM-1:0]   udf_vec;

    clr_state_e                   state_q, state_d;
    logic                         state_bit_q;
    logic [SET_WIDTH-1:0]         clr_idx_q, clr_idx_d;
    logic                         busy_d;

    logic [WAY_NUM*CNT_WIDTH-1:0] rd_cnt_c;
    logic [WAY_NUM-1:0]           rd_mask_c;
    logic [1:0]                   err_d;
    logic [1:0]                   err_q;

    // Clear sweep next-state logic.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = clr_busy;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d   = CLR_SWEEP;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            CLR_SWEEP: begin
                clr_idx_d = clr_idx_q + SET_WIDTH'(1);
                if (clr_idx_q == SET_WIDTH'(SET_NUM - 1)) begin
                    state_d = CLR_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign state_q = clr_state_e'(state_bit_q);

    ns_gnrl_dfflr #(.DW(1)) u_state (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (state_d), .qout (state_bit_q)
    );
    ns_gnrl_dfflr #(.DW(SET_WIDTH)) u_clr_idx (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (clr_idx_d), .qout (clr_idx_q)
    );
    ns_gnrl_dfflr #(.DW(1)) u_busy (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (busy_d), .qout (clr_busy)
    );

    for (genvar s = 0; s < SET_NUM; s++) begin : g_set
        for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
            logic [NI_W-1:0] n_inc_c;
            logic            dec_hit_c;
            logic            clr_hit_c;

            // Count increment ports addressing this entry.
            always_comb begin
                n_inc_c = '0;
                for (int p = 0; p < INC_PORTS; p++) begin
                    if (inc_valid[p]
                        && inc_set[p*SET_WIDTH +: SET_WIDTH] == SET_WIDTH'(s)
                        && inc_way[p*WAY_IDX_W +: WAY_IDX_W] == WAY_IDX_W'(w)) begin
                        n_inc_c = n_inc_c + NI_W'(1);
                    end
                end
            end

            assign dec_hit_c = dec_valid
                               && dec_way_set[SET_WIDTH-1:0] == SET_WIDTH'(s)
                               && dec_way_set[SET_WIDTH +: WAY_IDX_W] == WAY_IDX_W'(w);
            assign clr_hit_c = (state_q == CLR_SWEEP) && (clr_idx_q == SET_WIDTH'(s));

            ref_cnt_cell #(.CNT_WIDTH(CNT_WIDTH), .NI_W(NI_W)) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .n_inc     (n_inc_c),
                .d         (dec_hit_c),
                .clr       (clr_hit_c),
                .cnt       (cnt_q[s][w]),
                .cnt_nxt   (cnt_nxt[s][w]),
                .ovf_pulse (ovf_vec[s*WAY_NUM + w]),
                .udf_pulse (udf_vec[s*WAY_NUM + w])
            );
        end
    end

    // Lookup mux: pre-update values, or post-update values when bypass is built in.
    always_comb begin
        rd_cnt_c  = '0;
        rd_mask_c = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            rd_cnt_c[w*CNT_WIDTH +: CNT_WIDTH] = RD_BYPASS ? cnt_nxt[rd_set][w] : cnt_q[rd_set][w];
            rd_mask_c[w] = |rd_cnt_c[w*CNT_WIDTH +: CNT_WIDTH];
        end
    end

    ns_gnrl_dfflr #(.DW(1)) u_rsp_valid (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (rd_valid), .qout (rsp_valid)
    );
    ns_gnrl_dfflr #(.DW(WAY_NUM*CNT_WIDTH)) u_rsp_cnt (
        .clk (clk), .rst_n (rst_n), .lden (rd_valid), .dnxt (rd_cnt_c), .qout (rsp_cnt)
    );
    ns_gnrl_dfflr #(.DW(WAY_NUM)) u_rsp_mask (
        .clk (clk), .rst_n (rst_n), .lden (rd_valid), .dnxt (rd_mask_c), .qout (rsp_ref_mask)
    );

    // Sticky errors: a new error beats err_clr in the same cycle.
    assign err_d[0] = (|ovf_vec) | (err_q[0] & ~err_clr);
    assign err_d[1] = (|udf_vec) | (err_q[1] & ~err_clr);

    ns_gnrl_dfflr #(.DW(2)) u_err (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (err_d), .qout (err_q)
    );

    assign err_ovf = err_q[0];
    assign err_udf = err_q[1];

endmodule
